reg_bank_write_ctrl: RTL and testbench

- Write controller and arbiter for a bank of DEPTH parameterizable registers.
- Each bank register captures data on the rising edge of its own push strobe and clears on the shared active-low reset.
- Shares the bank among NREQ requesters using round-robin arbitration.
- Sequences every write as: data setup, then a single registered glitch-free push pulse, then release. Each push line is a capture edge, so it must never glitch.

---
 rtl/reg_bank_write_ctrl.sv | 153 +++++++++++++++
 tb/tb_reg_bank_write_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_write_ctrl.sv
// Round-robin write controller for a DEPTH-entry register bank: setup, one-cycle push, release.
// Optional feature macro: REG_BANK_ADDR_ERR_EN adds err_o, which flags out-of-range addresses.
module reg_bank_write_ctrl #(
  parameter  int N     = 32,
  parameter  int NREQ  = 4,
  parameter  int DEPTH = 6,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*N-1:0]  data_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    ack_o,
  output logic               busy_o,
  output logic [DEPTH-1:0]   push_o,
`ifdef REG_BANK_ADDR_ERR_EN
  output logic               err_o,
`endif
  output logic [N-1:0]       wdata_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [DEPTH-1:0]  push_q, push_d;
  logic [N-1:0]      wdata_q, wdata_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic              err_q, err_d;

  logic              found;
  logic [PW-1:0]     win;
  logic [AW-1:0]     sel_addr;
  logic [N-1:0]      sel_data;

  // Round-robin pick: scan starting one past the last grant, wrapping.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req_i[(int'(ptr_q) + i) % NREQ]) begin
        found = 1'b1;
        win   = PW'((int'(ptr_q) + i) % NREQ);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (k == int'(win)) begin
        sel_addr = addr_i[k*AW +: AW];
        sel_data = data_i[k*N +: N];
      end
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    busy_d  = busy_q;
    push_d  = '0;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    ptr_d   = ptr_q;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (found) begin
          state_d    = SETUP;
          gnt_d[win] = 1'b1;
          busy_d     = 1'b1;
          addr_d     = sel_addr;
          wdata_d    = sel_data;
          ptr_d      = win;
        end
      end
      SETUP: begin
        state_d = STROBE;
        // Decoding an out-of-range address matches no entry, so no push fires.
        for (int d = 0; d < DEPTH; d++) begin
          push_d[d] = (addr_q == AW'(d));
        end
      end
      STROBE: begin
        state_d = RELEASE;
        ack_d   = gnt_q;
        err_d   = (int'(addr_q) >= DEPTH);
      end
      RELEASE: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come straight from flops, so each push line is a clean capture edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      push_q  <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      ptr_q   <= PW'(NREQ - 1);
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from the same pre-edge values.
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      push_q  <= push_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign ack_o   = ack_q;
  assign busy_o  = busy_q;
  assign push_o  = push_q;
  assign wdata_o = wdata_q;

`ifdef REG_BANK_ADDR_ERR_EN
  assign err_o = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_reg_bank_write_ctrl.sv
// Directed bench for reg_bank_write_ctrl: reset, single write, round-robin, async reset,
// out-of-range address and input churn, with a push-edge model of the register bank.
module tb_reg_bank_write_ctrl;

  localparam int N     = 32;
  localparam int NREQ  = 4;
  localparam int DEPTH = 6;
  localparam int AW    = $clog2(DEPTH);

  logic               clk_i;
  logic               rst_i;
  logic [NREQ-1:0]    req_i;
  logic [NREQ*AW-1:0] addr_i;
  logic [NREQ*N-1:0]  data_i;
  logic [NREQ-1:0]    gnt_o;
  logic [NREQ-1:0]    ack_o;
  logic               busy_o;
  logic [DEPTH-1:0]   push_o;
  logic [N-1:0]       wdata_o;
`ifdef REG_BANK_ADDR_ERR_EN
  logic               err_o;
`endif

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] bank [DEPTH];

  reg_bank_write_ctrl #(.N(N), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .addr_i  (addr_i),
    .data_i  (data_i),
    .gnt_o   (gnt_o),
    .ack_o   (ack_o),
    .busy_o  (busy_o),
    .push_o  (push_o),
`ifdef REG_BANK_ADDR_ERR_EN
    .err_o   (err_o),
`endif
    .wdata_o (wdata_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Bank model: each register captures wdata_o on the rising edge of its own push line.
  for (genvar g = 0; g < DEPTH; g++) begin : g_bank
    always @(posedge push_o[g] or negedge rst_i) begin
      if (!rst_i) bank[g] <= '0;
      else        bank[g] <= wdata_o;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_slot(input int k, input logic [AW-1:0] a, input logic [N-1:0] d);
    addr_i[k*AW +: AW] = a;
    data_i[k*N +: N]   = d;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    req_i = '0;
    tick();
    tick();
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
  endtask

  initial begin
    rst_i  = 1'b0;
    req_i  = NREQ'($urandom);
    addr_i = NREQ*AW'($urandom);
    data_i = {$urandom, $urandom, $urandom, $urandom};

    // 1. Reset with random inputs, then idle.
    tick();
    tick();
    check("rst_gnt",   gnt_o,   0);
    check("rst_ack",   ack_o,   0);
    check("rst_busy",  busy_o,  0);
    check("rst_push",  push_o,  0);
    check("rst_wdata", wdata_o, 0);
    req_i = '0;
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    tick();
    tick();
    check("idle_busy", busy_o, 0);
    check("idle_gnt",  gnt_o,  0);

    // 2. Single write from requester 0 to address 3.
    set_slot(0, 3'd3, 32'hA5A5A5A5);
    req_i = 4'b0001;
    tick();
    check("w1_setup_wdata", wdata_o, 32'hA5A5A5A5);
    check("w1_setup_gnt",   gnt_o,   4'b0001);
    check("w1_setup_busy",  busy_o,  1);
    check("w1_setup_push",  push_o,  0);
    tick();
    check("w1_strobe_push", push_o, 6'b001000);
    check("w1_strobe_ack",  ack_o,  0);
    tick();
    check("w1_rel_push",  push_o,  0);
    check("w1_rel_ack",   ack_o,   4'b0001);
    check("w1_rel_wdata", wdata_o, 32'hA5A5A5A5);
`ifdef REG_BANK_ADDR_ERR_EN
    check("w1_rel_err", err_o, 0);
`endif
    req_i = '0;
    tick();
    check("w1_idle_ack",  ack_o,  0);
    check("w1_idle_busy", busy_o, 0);
    check("w1_idle_gnt",  gnt_o,  0);
    check("w1_bank3",     bank[3], 32'hA5A5A5A5);

    // 3. All four request together after reset: grants 0,1,2,3, acks four cycles apart.
    do_reset();
    for (int k = 0; k < NREQ; k++) set_slot(k, AW'(k), 32'h1000_0000 + N'(k));
    req_i = 4'b1111;
    for (int t = 0; t < NREQ; t++) begin
      tick();
      check($sformatf("rr_gnt%0d", t), gnt_o, 64'(1) << t);
      tick();
      check($sformatf("rr_push%0d", t), push_o, 64'(1) << t);
      tick();
      check($sformatf("rr_ack%0d", t), ack_o, 64'(1) << t);
      req_i[t] = 1'b0;
      tick();
    end
    for (int k = 0; k < NREQ; k++)
      check($sformatf("rr_bank%0d", k), bank[k], 32'h1000_0000 + k);

    // Single write by requester 2 leaves the pointer at 2; then 1 and 3 contend.
    req_i = 4'b0100;
    repeat (3) tick();
    req_i = '0;
    tick();
    req_i = 4'b1010;
    tick();
    check("rr2_gnt_a", gnt_o, 4'b1000);
    tick();
    tick();
    check("rr2_ack_a", ack_o, 4'b1000);
    req_i[3] = 1'b0;
    tick();
    tick();
    check("rr2_gnt_b", gnt_o, 4'b0010);
    tick();
    tick();
    check("rr2_ack_b", ack_o, 4'b0010);
    req_i[1] = 1'b0;
    tick();

    // 4. Async reset lands during STROBE of a write to address 5.
    set_slot(0, 3'd5, 32'hCAFEF00D);
    req_i = 4'b0001;
    tick();
    tick();
    check("ar_strobe_push", push_o, 6'b100000);
    #2;
    rst_i = 1'b0;
    #1;
    check("ar_push_falls", push_o, 0);
    check("ar_busy",       busy_o, 0);
    check("ar_gnt",        gnt_o,  0);
    check("ar_bank5",      bank[5], 0);
    req_i = '0;
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    check("ar_no_ack", ack_o, 0);
    // Pointer back at NREQ-1 means requester 0 beats requester 2.
    set_slot(2, 3'd5, 32'h0BADF00D);
    req_i = 4'b0101;
    tick();
    check("ar_ptr_gnt", gnt_o, 4'b0001);
    tick();
    tick();
    req_i[0] = 1'b0;
    tick();
    tick();
    check("ar_next_gnt", gnt_o, 4'b0100);
    tick();
    check("ar_next_push", push_o, 6'b100000);
    tick();
    check("ar_next_ack", ack_o, 4'b0100);
    req_i = '0;
    tick();
    check("ar_next_bank5", bank[5], 32'h0BADF00D);

    // 5. Out-of-range address: full sequence and ack, but no push.
    set_slot(1, 3'd7, 32'h1);
    req_i = 4'b0010;
    tick();
    check("oor_setup_wdata", wdata_o, 32'h1);
    check("oor_setup_push",  push_o,  0);
    tick();
    check("oor_strobe_push", push_o, 0);
    tick();
    check("oor_ack",      ack_o,  4'b0010);
    check("oor_rel_push", push_o, 0);
`ifdef REG_BANK_ADDR_ERR_EN
    check("oor_err", err_o, 1);
`endif
    req_i = '0;
    tick();
    check("oor_idle_busy", busy_o, 0);
`ifdef REG_BANK_ADDR_ERR_EN
    check("oor_err_clear", err_o, 0);
`endif

    // 6. Input churn during SETUP is ignored.
    set_slot(0, 3'd2, 32'h12345678);
    req_i = 4'b0001;
    tick();
    set_slot(0, 3'd4, 32'hDEADBEEF);
    req_i = 4'b1111;
    tick();
    check("churn_push",  push_o,  6'b000100);
    check("churn_wdata", wdata_o, 32'h12345678);
    tick();
    check("churn_ack", ack_o, 4'b0001);
    req_i = '0;
    tick();
    check("churn_bank2", bank[2], 32'h12345678);
    check("churn_bank4", bank[4], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
